majority_vote_filter: RTL
=========================

# majority_vote_filter

Parametrised, registered N-input threshold voter with temporal hysteresis. It generalises the 5-input majority/override control function to N channels, a programmable vote threshold and a HOLD-sample stability filter. It sits between sampled redundant control inputs and downstream control logic. It delivers a raw per-sample vote, a debounced decision, and an optional per-channel fault monitor.

## Interface
- N, 5, number of voting channels (1..32)
- THRESH, (N+1)/2, minimum asserted channels for a 1 vote (1..N; elaboration error otherwise)
- HOLD, 4, consecutive disagreeing valid samples required to flip the filtered output (1..255)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample strobe; in_vote/ovr sampled only when high
- in_vote  input  N  channel votes
- ovr  input  1  override; forces vote to 1 for that sample
- out_valid  output  1  stage-1 result valid, one pulse per accepted sample
- count  output  $clog2(N+1)  popcount of last accepted in_vote
- vote_raw  output  1  (count >= THRESH) | ovr, last accepted sample
- f  output  1  filtered decision
- changed  output  1  one-cycle pulse when f toggles
- fault  output  N  per-channel fault flags (present only with MAJ_DISAGREE_EN)

## Operation
- Stage 1, on in_valid: count <= popcount(in_vote). vote_raw <= (popcount >= THRESH) | ovr. ovr_q <= ovr. out_valid <= 1. Without in_valid: out_valid <= 0; count and vote_raw hold.
- Stage 2 filter FSM, evaluated only in cycles with out_valid=1:
  - States: STABLE (run counter = 0) and PENDING (run counter > 0).
  - vote_raw == f: go to or stay in STABLE; counter cleared.
  - vote_raw != f: counter increments. When counter reaches HOLD, f <= vote_raw, changed pulses, counter clears, state returns to STABLE.
  - ovr_q = 1: f <= 1 immediately, counter cleared, state STABLE. changed pulses only if f was 0.
- Cycles without out_valid do not advance, clear or reset the counter. Gaps between samples are transparent to the filter.
- Run counter width is $clog2(HOLD+1) and never exceeds HOLD.
- HOLD = 1: f follows vote_raw on every valid sample.

## Timing
- Reset values: out_valid=0, count=0, vote_raw=0, f=0, changed=0, fault=0, FSM STABLE, run counter 0, all disagree counters 0.
- Reset wins over in_valid in the same cycle. Reset mid-PENDING discards the partial run.
- Latency: in_valid at edge t gives count/vote_raw/out_valid at t+1, and f/changed at t+2 at the earliest.
- Full throughput: a new sample may be accepted every cycle. There is no backpressure.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- MAJ_DISAGREE_EN defined: adds one 4-bit saturating counter per channel.
  - Updated in stage 2 on each out_valid cycle.
  - Increments when in_vote[i] (registered copy) differs from vote_raw, saturating at 15.
  - Decrements on agreement, floor 0.
  - fault[i] is set when its counter reaches 15 and is sticky until rst.
  - Samples with ovr_q=1 do not update the counters.
- MAJ_DISAGREE_EN undefined: the fault port, the counters and the registered in_vote copy are absent. All other behaviour is identical.

## Test plan
All cases use N=5, THRESH=3, HOLD=4.
- Reset then idle: rst for 2 cycles, in_valid=0 -> all outputs 0 and stay 0 for 10 cycles.
- Raw vote threshold: in_vote=5'b00111 valid, then 5'b00011 -> vote_raw=1 with count=3 at t+1, then vote_raw=0 with count=2. out_valid pulses once per sample.
- Hysteresis:
  - Three valid 5'b11100 samples -> f stays 0.
  - A fourth sample -> f=1 and changed pulses once.
  - Variant 1 then 0 then 1 1 1 1 -> f flips only after the last 4.
- Gaps and override:
  - 4 valid samples of 5'b11111 separated by idle cycles -> f=1 after the 4th. Idle cycles are ignored.
  - Later, ovr=1 with in_vote=0 while f=0 -> f=1 at t+2, changed=1.
- Reset mid-run: 3 disagreeing samples then rst -> f=0, and 4 fresh samples are needed to flip.
- MAJ_DISAGREE_EN: channel 0 stuck at 1 while others send 0 for 15 samples -> fault=5'b00001 after the 15th. It stays set after channel 0 recovers, until rst.

Source files
------------

// File: rtl/majority_vote_filter_if.sv
// majority_vote_filter_if: sample/result bundle between the redundant-input
// sampler and the voter. The fault vector only exists when MAJ_DISAGREE_EN
// is defined.
interface majority_vote_filter_if #(
  parameter int N = 5
);
  localparam int CW = $clog2(N + 1);

  logic          in_valid;
  logic [N-1:0]  in_vote;
  logic          ovr;
  logic          out_valid;
  logic [CW-1:0] count;
  logic          vote_raw;
  logic          f;
  logic          changed;
`ifdef MAJ_DISAGREE_EN
  logic [N-1:0]  fault;

  modport master (
    output in_valid, in_vote, ovr,
    input  out_valid, count, vote_raw, f, changed, fault
  );

  modport slave (
    input  in_valid, in_vote, ovr,
    output out_valid, count, vote_raw, f, changed, fault
  );
`else
  modport master (
    output in_valid, in_vote, ovr,
    input  out_valid, count, vote_raw, f, changed
  );

  modport slave (
    input  in_valid, in_vote, ovr,
    output out_valid, count, vote_raw, f, changed
  );
`endif
endinterface

// File: rtl/majority_vote_filter.sv
// majority_vote_filter: registered N-input threshold voter followed by a
// HOLD-sample hysteresis filter on the vote.
// Optional macro MAJ_DISAGREE_EN adds a per-channel 4-bit disagreement
// counter and a sticky fault flag per channel.
//
// Filter FSM states:
//   state      | meaning
//   ST_STABLE  | run counter is 0, f agrees with the last evaluated vote
//   ST_PENDING | run counter > 0, counting consecutive disagreeing samples
module majority_vote_filter #(
  parameter int N      = 5,
  parameter int THRESH = (N + 1) / 2,
  parameter int HOLD   = 4
) (
  input logic                   clk,
  input logic                   rst,
  majority_vote_filter_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int RW = $clog2(HOLD + 1);

  if (N < 1 || N > 32) begin : g_bad_n
    $error("majority_vote_filter: N must be in 1..32");
  end
  if (THRESH < 1 || THRESH > N) begin : g_bad_thresh
    $error("majority_vote_filter: THRESH must be in 1..N");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("majority_vote_filter: HOLD must be in 1..255");
  end

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic          vote_raw_q, vote_raw_d;
  logic          ovr_q, ovr_d;
  logic [CW-1:0] pop;

  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [RW-1:0] run_base, run_inc;
  logic          f_q, f_d;
  logic          changed_q, changed_d;

  // Stage 1 next-state: popcount and threshold of the accepted sample
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(bus.in_vote[i]);
    end
    out_valid_d = bus.in_valid;
    count_d     = count_q;
    vote_raw_d  = vote_raw_q;
    ovr_d       = ovr_q;
    if (bus.in_valid) begin
      count_d    = pop;
      vote_raw_d = (pop >= CW'(THRESH)) | bus.ovr;
      ovr_d      = bus.ovr;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      count_q     <= '0;
      vote_raw_q  <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      vote_raw_q  <= vote_raw_d;
      ovr_q       <= ovr_d;
    end
  end

  // Stage 2 next-state: hysteresis run counter, advanced only on valid results
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    f_d       = f_q;
    changed_d = 1'b0;
    run_base  = (state_q == ST_PENDING) ? run_q : '0;
    run_inc   = run_base + RW'(1);
    if (out_valid_q) begin
      if (ovr_q) begin
        f_d       = 1'b1;
        changed_d = ~f_q;
        run_d     = '0;
        state_d   = ST_STABLE;
      end else if (vote_raw_q == f_q) begin
        run_d   = '0;
        state_d = ST_STABLE;
      end else if (run_inc == RW'(HOLD)) begin
        f_d       = vote_raw_q;
        changed_d = 1'b1;
        run_d     = '0;
        state_d   = ST_STABLE;
      end else begin
        run_d   = run_inc;
        state_d = ST_PENDING;
      end
    end
  end

  // Stage 2 filter FSM with registered f/changed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STABLE;
      run_q     <= '0;
      f_q       <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      f_q       <= f_d;
      changed_q <= changed_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;
  assign bus.vote_raw  = vote_raw_q;
  assign bus.f         = f_q;
  assign bus.changed   = changed_q;

`ifdef MAJ_DISAGREE_EN
  logic [N-1:0]      vote_q, vote_d;
  logic [N-1:0][3:0] dis_q, dis_d;
  logic [N-1:0]      fault_q, fault_d;

  // Per-channel saturating disagreement counters; override samples are skipped
  always_comb begin
    vote_d  = bus.in_valid ? bus.in_vote : vote_q;
    dis_d   = dis_q;
    fault_d = fault_q;
    if (out_valid_q && !ovr_q) begin
      for (int i = 0; i < N; i++) begin
        if (vote_q[i] != vote_raw_q) begin
          if (dis_q[i] != 4'hF) dis_d[i] = dis_q[i] + 4'd1;
        end else if (dis_q[i] != 4'h0) begin
          dis_d[i] = dis_q[i] - 4'd1;
        end
        if (dis_d[i] == 4'hF) fault_d[i] = 1'b1;
      end
    end
  end

  // Disagreement registers; fault flags are sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vote_q  <= '0;
      dis_q   <= '0;
      fault_q <= '0;
    end else begin
      vote_q  <= vote_d;
      dis_q   <= dis_d;
      fault_q <= fault_d;
    end
  end

  assign bus.fault = fault_q;
`endif
endmodule
